// File: rtl/param_counter_pkg.sv
// Shared definitions for the parameterised up/down counter: saturation
// encodings and the parameter legality check used at elaboration.
package param_counter_pkg;

    localparam int WRAP = 0;
    localparam int SAT  = 1;

    // MODULUS must fit the counter width and leave at least two states.
    function automatic bit params_ok(input int width, input int modulus, input int prescale);
        longint span;
        span = longint'(1) << width;
        return (modulus >= 2) && (longint'(modulus) <= span) && (prescale >= 1) && (width >= 1);
    endfunction

endpackage

// File: rtl/param_counter_clock_prescaler.sv
// Enable divider: emits one step for every PRESCALE enabled cycles; clear
// restarts the division from zero.
module clock_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_direct
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset, clear};
            assign step = enable;
        end else begin : g_count
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] count_q;
            logic [PW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (enable) begin
                    count_d = (count_q == LAST) ? '0 : count_q + PW'(1);
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign step = enable && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/param_counter.sv
// Modulo up/down counter with prescaled enable, clamped synchronous load,
// wrap or saturate at the range ends, and a one-cycle rollover pulse.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             rollover,
    output logic             at_limit
);

    generate
        if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
            $error("param_counter: illegal WIDTH/MODULUS/PRESCALE combination");
        end
    endgenerate

    // One extra bit so MODULUS = 2**WIDTH still has a representable top value.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

    logic             step;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic             rollover_q;
    logic             rollover_d;
    logic             at_top;
    logic             at_bottom;

    clock_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .clear (load),
        .step  (step)
    );

    assign at_top    = ({1'b0, counter_q} == MAX_EXT);
    assign at_bottom = (counter_q == '0);

    always_comb begin
        counter_d  = counter_q;
        rollover_d = 1'b0;
        if (load) begin
            counter_d = ({1'b0, load_value} > MAX_EXT) ? MAX_VAL : load_value;
        end else if (step) begin
            if (up) begin
                if (!at_top) begin
                    counter_d = counter_q + WIDTH'(1);
                end else if (SATURATE == WRAP) begin
                    counter_d  = '0;
                    rollover_d = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    counter_d = counter_q - WIDTH'(1);
                end else if (SATURATE == WRAP) begin
                    counter_d  = MAX_VAL;
                    rollover_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q  <= '0;
            rollover_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            rollover_q <= rollover_d;
        end
    end

    assign counter  = counter_q;
    assign rollover = rollover_q;
    assign at_limit = up ? at_top : at_bottom;

endmodule
